// File: rtl/cfu_types_pkg.sv
// cfu_types: status codes, function codes, response payload and helpers shared by cfu_mac_unit
package cfu_types;
   localparam int CFU_REQ_ID_W = 4;
   localparam int CFU_STATUS_W = 3;
   localparam int CFU_DATA_W   = 32;
   localparam logic [CFU_STATUS_W-1:0] CFU_STATUS_OK      = 3'd0;
   localparam logic [CFU_STATUS_W-1:0] CFU_STATUS_ERR_CFU = 3'd1;
   localparam logic [CFU_STATUS_W-1:0] CFU_STATUS_ERR_OP  = 3'd2;
   typedef enum logic [2:0] {
      FUNC_ADD    = 3'd0,
      FUNC_MAC    = 3'd1,
      FUNC_ACC_RD = 3'd2,
      FUNC_ACC_WR = 3'd3,
      FUNC_POPCNT = 3'd4
   } cfu_func_t;
   typedef struct packed {
      logic [CFU_REQ_ID_W-1:0] id;
      logic [CFU_STATUS_W-1:0] status;
      logic [CFU_DATA_W-1:0]   data;
   } cfu_resp_t;
   function automatic logic [CFU_DATA_W-1:0] cfu_popcnt(input logic [CFU_DATA_W-1:0] x);
      logic [CFU_DATA_W-1:0] r;
      r = '0;
      for (int i = 0; i < CFU_DATA_W; i++) r = r + CFU_DATA_W'(x[i]);
      return r;
   endfunction
endpackage

// File: rtl/cfu_resp_fifo.sv
// cfu_resp_fifo: in-order response buffer; count feeds the unit's request credit check
module cfu_resp_fifo
   import cfu_types::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  cfu_resp_t                push_data,
   input  logic                     pop,
   output logic                     out_valid,
   output cfu_resp_t                out_data,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   cfu_resp_t mem_q [DEPTH];
   cfu_resp_t mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0] count_q, count_d;
   logic take;
   assign out_valid = count_q != '0;
   assign out_data  = mem_q[rd_q];
   assign count     = count_q;
   assign take      = pop && out_valid;
   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wr_q] = push_data;
      wr_d    = wr_q + AW'(push);
      rd_d    = rd_q + AW'(take);
      count_d = count_q + (AW+1)'(push) - (AW+1)'(take);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q   <= '{default: '0};
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end
   // credits upstream must make an overflowing push impossible
   assert property (@(posedge clk) disable iff (!rst) !(push && !take && count_q == (AW+1)'(DEPTH)));
endmodule

// File: rtl/cfu_mac_unit.sv
// cfu_mac_unit: CFU integer/MAC unit with per-state accumulators and a credited response FIFO.
// Define CFU_MAC_SATURATE_EN for signed saturating MAC; default build wraps.
module cfu_mac_unit
   import cfu_types::*;
#(
   parameter int REQ_ID_W   = CFU_REQ_ID_W,
   parameter int CFU_ID_W   = 4,
   parameter int STATE_ID_W = 2,
   parameter int FUNC_ID_W  = 3,
   parameter int INSN_W     = 32,
   parameter int DATA_W     = CFU_DATA_W,
   parameter int STATUS_W   = CFU_STATUS_W,
   parameter int CFU_ID     = 0,
   parameter int RESP_DEPTH = 4
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_en,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_cfu_csr,
   input  logic [REQ_ID_W-1:0]   req_id,
   input  logic [CFU_ID_W-1:0]   req_cfu,
   input  logic [STATE_ID_W-1:0] req_state,
   input  logic [FUNC_ID_W-1:0]  req_func,
   input  logic [INSN_W-1:0]     req_insn,
   input  logic [DATA_W-1:0]     req_data0,
   input  logic [DATA_W-1:0]     req_data1,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [REQ_ID_W-1:0]   resp_id,
   output logic [STATUS_W-1:0]   resp_status,
   output logic [DATA_W-1:0]     resp_data
);
   localparam int CW = $clog2(RESP_DEPTH) + 1;
   logic accept, ok, insn_unused;
   logic [CW-1:0] fifo_count;
   logic s1_v_q, s1_v_d;
   logic [REQ_ID_W-1:0] s1_id_q, s1_id_d;
   logic [STATE_ID_W-1:0] s1_state_q, s1_state_d;
   logic [FUNC_ID_W-1:0] s1_func_q, s1_func_d;
   logic [STATUS_W-1:0] s1_status_q, s1_status_d;
   logic [DATA_W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_prod_q, s1_prod_d;
   logic [DATA_W-1:0] acc_q [2**STATE_ID_W];
   logic [DATA_W-1:0] acc_d [2**STATE_ID_W];
   logic [DATA_W-1:0] cur, mac, res;
`ifdef CFU_MAC_SATURATE_EN
   logic [DATA_W:0] sum;
`endif
   cfu_resp_t push_data, out_data;
   assign insn_unused = ^req_insn;
   // everything accepted but not yet consumed holds a FIFO slot, so S1 never stalls
   assign req_ready = rst && req_en && ({1'b0, fifo_count} + (CW+1)'(s1_v_q) < (CW+1)'(RESP_DEPTH));
   assign accept    = req_valid && req_ready;
   always_comb begin
      s1_v_d      = accept;
      s1_id_d     = req_id;
      s1_state_d  = req_state;
      s1_func_d   = req_func;
      s1_a_d      = req_data0;
      s1_b_d      = req_data1;
      s1_prod_d   = req_data0 * req_data1;
      s1_status_d = req_cfu != CFU_ID_W'(CFU_ID) ? CFU_STATUS_ERR_CFU
                  : (req_cfu_csr || req_func > FUNC_ID_W'(FUNC_POPCNT)) ? CFU_STATUS_ERR_OP
                  : CFU_STATUS_OK;
   end
   always_comb begin
      acc_d = acc_q;
      cur   = acc_q[s1_state_q];
      ok    = s1_v_q && s1_status_q == CFU_STATUS_OK;
`ifdef CFU_MAC_SATURATE_EN
      sum = {cur[DATA_W-1], cur} + {s1_prod_q[DATA_W-1], s1_prod_q};
      mac = sum[DATA_W] != sum[DATA_W-1] ? {sum[DATA_W], {(DATA_W-1){~sum[DATA_W]}}} : sum[DATA_W-1:0];
`else
      mac = cur + s1_prod_q;
`endif
      res = s1_func_q == FUNC_ADD ? s1_a_q + s1_b_q
          : s1_func_q == FUNC_MAC ? mac
          : (s1_func_q == FUNC_ACC_RD || s1_func_q == FUNC_ACC_WR) ? cur
          : s1_func_q == FUNC_POPCNT ? cfu_popcnt(s1_a_q)
          : '0;
      res = ok ? res : '0;
      if (ok && s1_func_q == FUNC_MAC) acc_d[s1_state_q] = mac;
      if (ok && s1_func_q == FUNC_ACC_WR) acc_d[s1_state_q] = s1_a_q;
   end
   assign push_data = '{id: s1_id_q, status: s1_status_q, data: res};
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_v_q      <= 1'b0;
         s1_id_q     <= '0;
         s1_state_q  <= '0;
         s1_func_q   <= '0;
         s1_status_q <= '0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_prod_q   <= '0;
         acc_q       <= '{default: '0};
      end else begin
         s1_v_q      <= s1_v_d;
         s1_id_q     <= s1_id_d;
         s1_state_q  <= s1_state_d;
         s1_func_q   <= s1_func_d;
         s1_status_q <= s1_status_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_prod_q   <= s1_prod_d;
         acc_q       <= acc_d;
      end
   end
   cfu_resp_fifo #(.DEPTH(RESP_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (s1_v_q),
      .push_data (push_data),
      .pop       (resp_ready),
      .out_valid (resp_valid),
      .out_data  (out_data),
      .count     (fifo_count)
   );
   assign resp_id     = out_data.id;
   assign resp_status = out_data.status;
   assign resp_data   = out_data.data;
endmodule

// File: tb/tb_cfu_mac_unit.sv
// tb_cfu_mac_unit: directed and randomized checks of cfu_mac_unit against a queue-based reference model
module tb_cfu_mac_unit;
   logic        clk = 1'b0;
   logic        rst, req_en, req_valid, req_ready, req_cfu_csr;
   logic [3:0]  req_id, req_cfu;
   logic [1:0]  req_state;
   logic [2:0]  req_func;
   logic [31:0] req_insn, req_data0, req_data1;
   logic        resp_valid, resp_ready;
   logic [3:0]  resp_id;
   logic [2:0]  resp_status;
   logic [31:0] resp_data;

   typedef struct {
      int          edge_n;
      logic [3:0]  id;
      logic [2:0]  st;
      logic [31:0] d;
   } exp_t;

   localparam longint SMAX = 64'sh7FFFFFFF;
   localparam longint SMIN = -64'sh80000000;

   exp_t q[$];
   exp_t got[$];
   logic [31:0] macc [4];
   int cyc = 0;
   int checks = 0;
   int errors = 0;

   cfu_mac_unit dut (
      .clk(clk), .rst(rst), .req_en(req_en), .req_valid(req_valid), .req_ready(req_ready),
      .req_cfu_csr(req_cfu_csr), .req_id(req_id), .req_cfu(req_cfu), .req_state(req_state),
      .req_func(req_func), .req_insn(req_insn), .req_data0(req_data0), .req_data1(req_data1),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_status(resp_status), .resp_data(resp_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Architectural effect of one accepted request, applied in acceptance order.
   function automatic exp_t model_req(input logic [3:0] id, input logic [3:0] cfu, input logic csr,
                                      input logic [1:0] st, input logic [2:0] fn,
                                      input logic [31:0] a, input logic [31:0] b);
      exp_t r;
      longint s;
      logic [31:0] p;
      r.edge_n = 0;
      r.id = id;
      r.st = 3'd0;
      r.d = '0;
      p = a * b;
      if (cfu != 4'd0) r.st = 3'd1;
      else if (csr || fn > 3'd4) r.st = 3'd2;
      else if (fn == 3'd0) r.d = a + b;
      else if (fn == 3'd1) begin
         s = longint'($signed(macc[st])) + longint'($signed(p));
`ifdef CFU_MAC_SATURATE_EN
         if (s > SMAX) s = SMAX;
         if (s < SMIN) s = SMIN;
`endif
         macc[st] = s[31:0];
         r.d = macc[st];
      end
      else if (fn == 3'd2) r.d = macc[st];
      else if (fn == 3'd3) begin
         r.d = macc[st];
         macc[st] = a;
      end
      else r.d = 32'($countones(a));
      return r;
   endfunction

   always @(negedge clk) begin : cmp
      exp_t e;
      logic exp_v;
      if (!rst) begin
         q.delete();
         foreach (macc[i]) macc[i] = '0;
         chk("rst_resp_valid", 32'(resp_valid), 32'd0);
         chk("rst_req_ready", 32'(req_ready), 32'd0);
         chk("rst_resp_id", 32'(resp_id), 32'd0);
         chk("rst_resp_status", 32'(resp_status), 32'd0);
         chk("rst_resp_data", resp_data, 32'd0);
      end else begin
         chk("req_ready", 32'(req_ready), 32'(req_en && q.size() < 4));
         exp_v = q.size() > 0 && cyc >= q[0].edge_n + 1;
         chk("resp_valid", 32'(resp_valid), 32'(exp_v));
         if (resp_valid && exp_v) begin
            chk("resp_id", 32'(resp_id), 32'(q[0].id));
            chk("resp_status", 32'(resp_status), 32'(q[0].st));
            chk("resp_data", resp_data, q[0].d);
         end
         if (req_valid && req_ready) begin
            e = model_req(req_id, req_cfu, req_cfu_csr, req_state, req_func, req_data0, req_data1);
            e.edge_n = cyc + 1;
            q.push_back(e);
         end
         if (resp_valid && resp_ready) begin
            e.edge_n = cyc;
            e.id = resp_id;
            e.st = resp_status;
            e.d = resp_data;
            got.push_back(e);
            if (q.size() > 0) void'(q.pop_front());
         end
      end
   end

   // Called just after a posedge; returns just after the posedge that accepted it, valid still high.
   task automatic send(input logic [3:0] id, input logic [3:0] cfu, input logic csr, input logic [1:0] st,
                       input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
      int t;
      req_valid = 1'b1;
      req_id = id;
      req_cfu = cfu;
      req_cfu_csr = csr;
      req_state = st;
      req_func = fn;
      req_data0 = a;
      req_data1 = b;
      req_insn = $urandom;
      for (t = 0; t < 200; t++) begin
         @(negedge clk);
         if (req_ready) break;
      end
      if (t == 200) chk("send_timeout", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req_valid = 1'b0;
      req_cfu_csr = 1'b0;
      req_cfu = 4'd0;
   endtask

   task automatic drain();
      idle();
      resp_ready = 1'b1;
      for (int t = 0; t < 200 && q.size() != 0; t++) @(negedge clk);
      chk("drain_empty", 32'(q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int b, n, f;
      rst = 1'b0;
      req_en = 1'b1;
      resp_ready = 1'b1;
      req_insn = '0;
      req_id = '0;
      req_state = '0;
      req_func = '0;
      req_data0 = '0;
      req_data1 = '0;
      idle();
      req_valid = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_req_ready", 32'(req_ready), 32'd0);
      chk("reset_resp_valid", 32'(resp_valid), 32'd0);
      idle();
      @(posedge clk);
      #1 rst = 1'b1;

      b = got.size();
      send(4'd5, 4'd0, 1'b0, 2'd0, 3'd0, 32'hFFFFFFFF, 32'd2);
      idle();
      @(negedge clk);
      chk("add_n1_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      chk("add_n2_valid", 32'(resp_valid), 32'd1);
      chk("add_id", 32'(resp_id), 32'd5);
      chk("add_status", 32'(resp_status), 32'd0);
      chk("add_data", resp_data, 32'h00000001);
      @(posedge clk);
      #1;
      drain();

      b = got.size();
      send(4'd1, 4'd0, 1'b0, 2'd1, 3'd1, 32'd3, 32'd4);
      send(4'd2, 4'd0, 1'b0, 2'd1, 3'd1, 32'd2, 32'hFFFFFFFF);
      send(4'd3, 4'd0, 1'b0, 2'd1, 3'd1, 32'd10, 32'd10);
      send(4'd4, 4'd0, 1'b0, 2'd1, 3'd2, 32'd0, 32'd0);
      send(4'd5, 4'd0, 1'b0, 2'd0, 3'd2, 32'd0, 32'd0);
      drain();
      chk("mac1", got[b].d, 32'd12);
      chk("mac2", got[b+1].d, 32'd10);
      chk("mac3", got[b+2].d, 32'd110);
      chk("rd_s1", got[b+3].d, 32'd110);
      chk("rd_s0", got[b+4].d, 32'd0);

      b = got.size();
      send(4'd6, 4'd3, 1'b0, 2'd1, 3'd1, 32'd5, 32'd5);
      send(4'd7, 4'd0, 1'b0, 2'd1, 3'd6, 32'd5, 32'd5);
      send(4'd8, 4'd0, 1'b1, 2'd1, 3'd0, 32'd5, 32'd5);
      send(4'd9, 4'd0, 1'b0, 2'd1, 3'd2, 32'd0, 32'd0);
      drain();
      chk("errcfu_status", 32'(got[b].st), 32'd1);
      chk("errcfu_data", got[b].d, 32'd0);
      chk("errop_status", 32'(got[b+1].st), 32'd2);
      chk("errop_data", got[b+1].d, 32'd0);
      chk("errcsr_status", 32'(got[b+2].st), 32'd2);
      chk("err_acc_kept", got[b+3].d, 32'd110);

      b = got.size();
      resp_ready = 1'b0;
      n = 0;
      req_valid = 1'b1;
      req_cfu = 4'd0;
      req_state = 2'd3;
      req_func = 3'd2;
      req_id = 4'd0;
      repeat (8) begin
         @(negedge clk);
         if (req_ready) n++;
         @(posedge clk);
         #1 req_id = 4'(n);
      end
      chk("bp_accepted", 32'(n), 32'd4);
      @(negedge clk);
      chk("bp_ready_low", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1 resp_ready = 1'b1;
      for (int t = 0; t < 50 && n < 6; t++) begin
         @(negedge clk);
         if (req_ready) n++;
         @(posedge clk);
         #1 req_id = 4'(n);
      end
      chk("bp_total", 32'(n), 32'd6);
      drain();
      for (int i = 0; i < 6; i++) chk("bp_order", 32'(got[b+i].id), 32'(i));

      b = got.size();
      send(4'd1, 4'd0, 1'b0, 2'd2, 3'd3, 32'h7FFFFFFF, 32'd0);
      send(4'd2, 4'd0, 1'b0, 2'd2, 3'd1, 32'd1, 32'd1);
      drain();
      chk("accwr_old", got[b].d, 32'd0);
`ifdef CFU_MAC_SATURATE_EN
      chk("mac_overflow", got[b+1].d, 32'h7FFFFFFF);
`else
      chk("mac_overflow", got[b+1].d, 32'h80000000);
`endif

      repeat (1500) begin
         req_valid = $urandom_range(0, 3) != 0;
         req_en = $urandom_range(0, 9) != 0;
         resp_ready = $urandom_range(0, 3) != 0;
         req_cfu = $urandom_range(0, 7) == 0 ? 4'($urandom_range(1, 15)) : 4'd0;
         req_cfu_csr = $urandom_range(0, 15) == 0;
         req_id = 4'($urandom);
         req_state = 2'($urandom);
         f = $urandom_range(0, 9);
         req_func = f > 7 ? 3'd1 : 3'(f);
         req_insn = $urandom;
         req_data0 = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 20)) - 32'd10;
         req_data1 = $urandom_range(0, 3) == 0 ? 32'h7FFFFFF0 : 32'($urandom_range(0, 40000)) - 32'd20000;
         @(posedge clk);
         #1;
      end
      req_en = 1'b1;
      drain();

      resp_ready = 1'b0;
      send(4'd1, 4'd0, 1'b0, 2'd0, 3'd1, 32'd7, 32'd7);
      send(4'd2, 4'd0, 1'b0, 2'd1, 3'd3, 32'd99, 32'd0);
      send(4'd3, 4'd0, 1'b0, 2'd3, 3'd1, 32'd5, 32'd5);
      idle();
      repeat (3) @(negedge clk);
      chk("pre_rst_valid", 32'(resp_valid), 32'd1);
      req_valid = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk("async_rst_valid", 32'(resp_valid), 32'd0);
      chk("async_rst_ready", 32'(req_ready), 32'd0);
      idle();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      resp_ready = 1'b1;
      b = got.size();
      for (int s = 0; s < 4; s++) send(4'(s), 4'd0, 1'b0, 2'(s), 3'd2, 32'd0, 32'd0);
      drain();
      for (int s = 0; s < 4; s++) chk("post_rst_acc", got[b+s].d, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
